// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side request/response buses and memory-side port of the memory arbiter.
interface mem_arbiter_if #(
  parameter int PADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int SIZE_W = 3
);
  logic ic_req_valid_i;
  logic [PADDR_W-1:0] ic_addr_i;
  logic ic_req_ready_o;
  logic ic_resp_valid_o;
  logic [LINE_W-1:0] ic_resp_data_o;
  logic dc_req_valid_i;
  logic dc_req_we_i;
  logic [PADDR_W-1:0] dc_addr_i;
  logic [SIZE_W-1:0] dc_size_i;
  logic [LINE_W-1:0] dc_wr_data_i;
  logic dc_req_ready_o;
  logic dc_resp_valid_o;
  logic [LINE_W-1:0] dc_resp_data_o;
  logic mem_rd_req_valid_o;
  logic mem_wr_req_valid_o;
  logic mem_req_is_instr_o;
  logic [PADDR_W-1:0] mem_address_o;
  logic [LINE_W-1:0] mem_wr_data_o;
  logic [SIZE_W-1:0] mem_access_size_o;
  logic mem_data_valid_i;
  logic mem_data_is_instr_i;
  logic [LINE_W-1:0] mem_data_i;
  modport slave (
    input ic_req_valid_i, ic_addr_i, dc_req_valid_i, dc_req_we_i, dc_addr_i, dc_size_i, dc_wr_data_i,
    input mem_data_valid_i, mem_data_is_instr_i, mem_data_i,
    output ic_req_ready_o, ic_resp_valid_o, ic_resp_data_o, dc_req_ready_o, dc_resp_valid_o, dc_resp_data_o,
    output mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o, mem_address_o, mem_wr_data_o, mem_access_size_o
  );
  modport master (
    output ic_req_valid_i, ic_addr_i, dc_req_valid_i, dc_req_we_i, dc_addr_i, dc_size_i, dc_wr_data_i,
    output mem_data_valid_i, mem_data_is_instr_i, mem_data_i,
    input ic_req_ready_o, ic_resp_valid_o, ic_resp_data_o, dc_req_ready_o, dc_resp_valid_o, dc_resp_data_o,
    input mem_rd_req_valid_o, mem_wr_req_valid_o, mem_req_is_instr_o, mem_address_o, mem_wr_data_o, mem_access_size_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one pipelined memory port between icache and dcache,
// with per-requester read tracking, tag-routed responses and a write-commit idle indication.
module mem_arbiter #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int WR_COMMIT_LAT = 5,
  parameter int LINE_W = 128,
  parameter int SIZE_W = 3,
  parameter logic [SIZE_W-1:0] LINE_SIZE = 4
) (
  input logic clk_i,
  input logic rst_i,
  mem_arbiter_if.slave bus,
  input logic drain_i,
  output logic idle_o,
  output logic err_o
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  typedef enum logic {GNT_IC, GNT_DC} gnt_e;
  gnt_e last_q, last_d;
  logic [CW-1:0] ic_cnt_q, ic_cnt_d, dc_cnt_q, dc_cnt_d;
  logic [WR_COMMIT_LAT-1:0] wr_sr_q, wr_sr_d;
  logic err_q, err_d, ic_rv_q, ic_rv_d, dc_rv_q, dc_rv_d;
  logic [LINE_W-1:0] ic_rd_q, ic_rd_d, dc_rd_q, dc_rd_d;
  logic ic_elig, dc_elig, ic_win, dc_win, ic_rsp, dc_rsp, ic_hit, dc_hit;
  always_comb begin
    ic_elig = bus.ic_req_valid_i && !drain_i && ic_cnt_q < MAX_CNT;
    dc_elig = bus.dc_req_valid_i && !drain_i && (bus.dc_req_we_i || dc_cnt_q < MAX_CNT);
    ic_win = ic_elig && (!dc_elig || last_q == GNT_DC);
    dc_win = dc_elig && !ic_win;
    ic_rsp = bus.mem_data_valid_i && bus.mem_data_is_instr_i;
    dc_rsp = bus.mem_data_valid_i && !bus.mem_data_is_instr_i;
    // a response with nothing outstanding is dropped rather than underflowing
    ic_hit = ic_rsp && ic_cnt_q != '0;
    dc_hit = dc_rsp && dc_cnt_q != '0;
    ic_cnt_d = ic_cnt_q + CW'(ic_win) - CW'(ic_hit);
    dc_cnt_d = dc_cnt_q + CW'(dc_win && !bus.dc_req_we_i) - CW'(dc_hit);
    wr_sr_d = {wr_sr_q[WR_COMMIT_LAT-2:0], dc_win && bus.dc_req_we_i};
    last_d = ic_win ? GNT_IC : dc_win ? GNT_DC : last_q;
    err_d = err_q || (ic_rsp && !ic_hit) || (dc_rsp && !dc_hit);
    ic_rv_d = ic_hit;
    dc_rv_d = dc_hit;
    ic_rd_d = ic_hit ? bus.mem_data_i : ic_rd_q;
    dc_rd_d = dc_hit ? bus.mem_data_i : dc_rd_q;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_q <= GNT_DC;
      ic_cnt_q <= '0;
      dc_cnt_q <= '0;
      wr_sr_q <= '0;
      err_q <= 1'b0;
      ic_rv_q <= 1'b0;
      dc_rv_q <= 1'b0;
      ic_rd_q <= '0;
      dc_rd_q <= '0;
    end else begin
      last_q <= last_d;
      ic_cnt_q <= ic_cnt_d;
      dc_cnt_q <= dc_cnt_d;
      wr_sr_q <= wr_sr_d;
      err_q <= err_d;
      ic_rv_q <= ic_rv_d;
      dc_rv_q <= dc_rv_d;
      ic_rd_q <= ic_rd_d;
      dc_rd_q <= dc_rd_d;
    end
  end
  assign bus.ic_req_ready_o = ic_win;
  assign bus.dc_req_ready_o = dc_win;
  assign bus.mem_rd_req_valid_o = ic_win || (dc_win && !bus.dc_req_we_i);
  assign bus.mem_wr_req_valid_o = dc_win && bus.dc_req_we_i;
  assign bus.mem_req_is_instr_o = ic_win;
  assign bus.mem_address_o = ic_win ? bus.ic_addr_i : bus.dc_addr_i;
  assign bus.mem_wr_data_o = bus.dc_wr_data_i;
  assign bus.mem_access_size_o = ic_win ? LINE_SIZE : bus.dc_size_i;
  assign bus.ic_resp_valid_o = ic_rv_q;
  assign bus.ic_resp_data_o = ic_rd_q;
  assign bus.dc_resp_valid_o = dc_rv_q;
  assign bus.dc_resp_data_o = dc_rd_q;
  assign idle_o = ic_cnt_q == '0 && dc_cnt_q == '0 && wr_sr_q == '0;
  assign err_o = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed bench with a fixed-latency memory and a
// queue-based reference model of arbitration, outstanding reads, responses and write commit.
module tb_mem_arbiter;
  localparam int MAXO = 8;
  localparam int LAT = 5;
  localparam int RD_LAT = 10;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic drain = 1'b0;
  logic idle, err;
  always #5 clk = ~clk;
  mem_arbiter_if bus ();
  mem_arbiter #(.MAX_OUTSTANDING(MAXO), .WR_COMMIT_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst_n), .bus(bus), .drain_i(drain), .idle_o(idle), .err_o(err)
  );
  typedef struct {int due; bit instr; logic [31:0] addr;} rd_t;
  rd_t pend[$];
  int wr_t[$];
  logic [127:0] mem [bit [31:0]];
  int cyc, ic_cnt, dc_cnt, checks, errors, n;
  bit last_ic, exp_err, exp_icv, exp_dcv, inj;
  logic [127:0] exp_icd, exp_dcd, a_ic_d, a_dc_d;
  logic a_ic_rdy, a_dc_rdy, a_wr, a_idle, a_err, a_ic_rv, a_dc_rv;
  logic [5:0] gv_i, gv_d, iv;
  function automatic logic [127:0] line_of(logic [31:0] a);
    return mem.exists(a) ? mem[a] : {4{32'hC0DE_0000 | a}};
  endfunction
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask
  // one clock: drive memory return, check outputs against the model, then advance the model past the edge
  task automatic step();
    bit ic_el, dc_el, gi, gd, we, mv, mi, ic_hit, dc_hit;
    logic [127:0] md;
    @(negedge clk);
    mv = 1'b0;
    mi = 1'b0;
    md = '0;
    if (inj) begin
      mv = 1'b1;
      mi = 1'b1;
      md = {4{32'hDEAD_BEEF}};
    end else if (pend.size() > 0 && pend[0].due == cyc) begin
      mv = 1'b1;
      mi = pend[0].instr;
      md = line_of(pend[0].addr);
    end
    bus.mem_data_valid_i = mv;
    bus.mem_data_is_instr_i = mi;
    bus.mem_data_i = md;
    #1;
    we = bus.dc_req_we_i;
    ic_el = bus.ic_req_valid_i && !drain && ic_cnt < MAXO;
    dc_el = bus.dc_req_valid_i && !drain && (we || dc_cnt < MAXO);
    gi = ic_el && (!dc_el || !last_ic);
    gd = dc_el && !gi;
    chk("ic_ready", bus.ic_req_ready_o, gi);
    chk("dc_ready", bus.dc_req_ready_o, gd);
    chk("mem_rd", bus.mem_rd_req_valid_o, gi || (gd && !we));
    chk("mem_wr", bus.mem_wr_req_valid_o, gd && we);
    if (gi || gd) begin
      chk("is_instr", bus.mem_req_is_instr_o, gi);
      chk("address", bus.mem_address_o, gi ? bus.ic_addr_i : bus.dc_addr_i);
      chk("size", bus.mem_access_size_o, gi ? 3'd4 : bus.dc_size_i);
    end
    if (gd && we) chk("wr_data", bus.mem_wr_data_o, bus.dc_wr_data_i);
    chk("idle", idle, ic_cnt == 0 && dc_cnt == 0 && wr_t.size() == 0);
    chk("err", err, exp_err);
    chk("ic_resp_valid", bus.ic_resp_valid_o, exp_icv);
    chk("dc_resp_valid", bus.dc_resp_valid_o, exp_dcv);
    if (exp_icv) chk("ic_resp_data", bus.ic_resp_data_o, exp_icd);
    if (exp_dcv) chk("dc_resp_data", bus.dc_resp_data_o, exp_dcd);
    a_ic_rdy = bus.ic_req_ready_o;
    a_dc_rdy = bus.dc_req_ready_o;
    a_wr = bus.mem_wr_req_valid_o;
    a_idle = idle;
    a_err = err;
    a_ic_rv = bus.ic_resp_valid_o;
    a_dc_rv = bus.dc_resp_valid_o;
    a_ic_d = bus.ic_resp_data_o;
    a_dc_d = bus.dc_resp_data_o;
    if (mv && !inj) pend.delete(0);
    if (gi || (gd && !we)) pend.push_back('{cyc + RD_LAT, gi, gi ? bus.ic_addr_i : bus.dc_addr_i});
    if (gd && we) begin
      mem[bus.dc_addr_i] = bus.dc_wr_data_i;
      wr_t.push_back(cyc);
    end
    ic_hit = mv && mi && ic_cnt > 0;
    dc_hit = mv && !mi && dc_cnt > 0;
    exp_err = exp_err || (mv && !ic_hit && !dc_hit);
    exp_icv = ic_hit;
    exp_dcv = dc_hit;
    if (ic_hit) exp_icd = md;
    if (dc_hit) exp_dcd = md;
    ic_cnt += int'(gi) - int'(ic_hit);
    dc_cnt += int'(gd && !we) - int'(dc_hit);
    if (gi) last_ic = 1'b1;
    else if (gd) last_ic = 1'b0;
    cyc++;
    while (wr_t.size() > 0 && cyc - wr_t[0] > LAT) wr_t.delete(0);
    inj = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle();
    int k;
    k = 0;
    while (k < 60 && !(pend.size() == 0 && wr_t.size() == 0 && ic_cnt == 0 && dc_cnt == 0)) begin
      step();
      k++;
    end
    if (k == 60) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout at cycle %0d: got busy, expected idle within 60 cycles", cyc);
    end
  endtask
  initial begin
    bus.ic_req_valid_i = 1'b0;
    bus.ic_addr_i = '0;
    bus.dc_req_valid_i = 1'b0;
    bus.dc_req_we_i = 1'b0;
    bus.dc_addr_i = '0;
    bus.dc_size_i = '0;
    bus.dc_wr_data_i = '0;
    bus.mem_data_valid_i = 1'b0;
    bus.mem_data_is_instr_i = 1'b0;
    bus.mem_data_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_idle", idle, 1'b1);
    chk("rst_err", err, 1'b0);
    chk("rst_ic_ready", bus.ic_req_ready_o, 1'b0);
    chk("rst_dc_ready", bus.dc_req_ready_o, 1'b0);
    chk("rst_mem_rd", bus.mem_rd_req_valid_o, 1'b0);
    chk("rst_mem_wr", bus.mem_wr_req_valid_o, 1'b0);
    chk("rst_ic_resp", bus.ic_resp_valid_o, 1'b0);
    chk("rst_dc_resp", bus.dc_resp_valid_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // contention from reset: IC wins first, then strict alternation
    bus.ic_req_valid_i = 1'b1;
    bus.dc_req_valid_i = 1'b1;
    bus.dc_size_i = 3'd2;
    gv_i = '0;
    gv_d = '0;
    for (int i = 0; i < 6; i++) begin
      bus.ic_addr_i = 32'h200 + 32'(i * 16);
      bus.dc_addr_i = 32'h300 + 32'(i * 16);
      step();
      gv_i = {gv_i[4:0], a_ic_rdy};
      gv_d = {gv_d[4:0], a_dc_rdy};
    end
    chk("contention_ic_order", gv_i, 6'b101010);
    chk("contention_dc_order", gv_d, 6'b010101);
    bus.ic_req_valid_i = 1'b0;
    bus.dc_req_valid_i = 1'b0;
    wait_idle();
    bus.ic_req_valid_i = 1'b1;
    bus.ic_addr_i = 32'h40;
    step();
    chk("ic_single_ready", a_ic_rdy, 1'b1);
    bus.ic_req_valid_i = 1'b0;
    repeat (10) step();
    chk("ic_single_early", a_ic_rv, 1'b0);
    step();
    chk("ic_single_valid", a_ic_rv, 1'b1);
    chk("ic_single_data", a_ic_d, 128'hC0DE0040_C0DE0040_C0DE0040_C0DE0040);
    chk("ic_single_dc_quiet", a_dc_rv, 1'b0);
    wait_idle();
    bus.ic_req_valid_i = 1'b1;
    n = 0;
    for (int i = 0; i < 11; i++) begin
      bus.ic_addr_i = 32'h1000 + 32'(i * 16);
      step();
      n += int'(a_ic_rdy);
    end
    chk("max_out_grants", n, 8);
    step();
    chk("max_out_resume", a_ic_rdy, 1'b1);
    bus.ic_req_valid_i = 1'b0;
    wait_idle();
    bus.dc_req_valid_i = 1'b1;
    bus.dc_req_we_i = 1'b1;
    bus.dc_addr_i = 32'h100;
    bus.dc_wr_data_i = {16{8'hA5}};
    bus.dc_size_i = 3'd4;
    step();
    chk("wr_ready", a_dc_rdy, 1'b1);
    chk("wr_strobe", a_wr, 1'b1);
    drain = 1'b1;
    bus.ic_req_valid_i = 1'b1;
    bus.dc_req_we_i = 1'b0;
    n = 0;
    iv = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      n += int'(a_ic_rdy) + int'(a_dc_rdy);
      iv = {iv[4:0], a_idle};
    end
    chk("drain_no_grant", n, 0);
    chk("wr_idle_seq", iv, 6'b000001);
    drain = 1'b0;
    bus.ic_req_valid_i = 1'b0;
    step();
    chk("rd_after_wr_ready", a_dc_rdy, 1'b1);
    bus.dc_req_valid_i = 1'b0;
    repeat (10) step();
    step();
    chk("rd_after_wr_valid", a_dc_rv, 1'b1);
    chk("rd_after_wr_data", a_dc_d, {16{8'hA5}});
    wait_idle();
    inj = 1'b1;
    step();
    step();
    chk("err_set", a_err, 1'b1);
    chk("err_no_ic_resp", a_ic_rv, 1'b0);
    chk("err_cnt_zero_idle", a_idle, 1'b1);
    repeat (3) step();
    chk("err_sticky", a_err, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      bus.ic_req_valid_i = $urandom_range(0, 2) != 0;
      bus.ic_addr_i = 32'($urandom_range(0, 15)) << 4;
      bus.dc_req_valid_i = $urandom_range(0, 2) != 0;
      bus.dc_req_we_i = $urandom_range(0, 2) == 0;
      bus.dc_addr_i = 32'($urandom_range(0, 15)) << 4;
      bus.dc_size_i = 3'($urandom_range(0, 7));
      bus.dc_wr_data_i = {$urandom, $urandom, $urandom, $urandom};
      drain = $urandom_range(0, 9) == 0;
      step();
    end
    bus.ic_req_valid_i = 1'b0;
    bus.dc_req_valid_i = 1'b0;
    drain = 1'b0;
    wait_idle();
    step();
    chk("final_idle", a_idle, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single fixed-latency pipelined memory port between the instruction cache (read-only line fills) and the data cache (line fills and write-backs). Performs round-robin arbitration, tracks outstanding reads per requester, and routes returning lines by the memory's instruction tag. Provides a drain/idle handshake so the core can confirm that every write has committed before signalling end of run. It sits between the two caches and the memory model.

## Interface
- MAX_OUTSTANDING, 8: maximum in-flight reads per requester (1..15).
- WR_COMMIT_LAT, 5: cycles from write issue to memory array update.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  reset, asynchronous, active-low.
- ic_req_valid_i  in  1  icache read request.
- ic_addr_i  in  paddr_t  icache line address.
- ic_req_ready_o  out  1  icache request accepted this cycle.
- ic_resp_valid_o  out  1  icache line valid.
- ic_resp_data_o  out  cacheline_t  icache line.
- dc_req_valid_i  in  1  dcache request.
- dc_req_we_i  in  1  1 = write-back, 0 = read.
- dc_addr_i  in  paddr_t  dcache address.
- dc_size_i  in  access_size_t  access size.
- dc_wr_data_i  in  cacheline_t  write-back data.
- dc_req_ready_o  out  1  dcache request accepted this cycle.
- dc_resp_valid_o  out  1  dcache line valid.
- dc_resp_data_o  out  cacheline_t  dcache line.
- mem_rd_req_valid_o, mem_wr_req_valid_o  out  1 each  memory request strobes.
- mem_req_is_instr_o  out  1  tag: 1 = icache.
- mem_address_o  out  paddr_t; mem_wr_data_o  out  cacheline_t; mem_access_size_o  out  access_size_t.
- mem_data_valid_i, mem_data_is_instr_i  in  1 each; mem_data_i  in  cacheline_t.
- drain_i  in  1  block new grants.
- idle_o  out  1  no reads or writes in flight.
- err_o  out  1  sticky: unexpected response.

## Operation
- Eligibility:
  - IC is eligible when ic_req_valid_i=1, ic_cnt < MAX_OUTSTANDING and drain_i=0.
  - DC is eligible when dc_req_valid_i=1, drain_i=0 and either (dc_req_we_i=1) or (dc_cnt < MAX_OUTSTANDING).
  - A response decrement in the same cycle does not free a slot.
- Arbitration:
  - One grant per cycle.
  - If only one requester is eligible, it wins.
  - If both are eligible, the requester not recorded in last_grant wins.
  - last_grant updates on every grant. Reset value is DC, so IC wins the first contest.
- Grant is combinational: ready_o=1 for the winner only.
- The memory request signals are a combinational mux of the winner:
  - mem_rd_req_valid_o = grant & !we.
  - mem_wr_req_valid_o = grant & we.
  - is_instr = IC winner.
  - IC uses the cache-line access size.
  - With no grant, both strobes are 0 and the other mem outputs are don't-care.
- Counters (width $clog2(MAX_OUTSTANDING+1)):
  - ic_cnt increments on an IC grant. dc_cnt increments on a DC read grant.
  - Each counter decrements on mem_data_valid_i with the matching tag.
  - Simultaneous increment and decrement leaves the counter unchanged.
- Response routing:
  - mem_data_valid_i & mem_data_is_instr_i → IC; mem_data_valid_i & !mem_data_is_instr_i → DC.
  - Data is registered; resp_valid pulses for 1 cycle.
  - A response whose target counter is 0 is dropped, sets err_o, and the counter stays 0 (no underflow).
- Write tracking: a WR_COMMIT_LAT-bit shift register shifts in mem_wr_req_valid_o each cycle. A write is committed when it leaves the register.
- idle_o = (ic_cnt==0) & (dc_cnt==0) & (write shift register == 0). Combinational.
- err_o clears only on reset.

## Timing
- Reset (asynchronous assert, synchronous-to-clock release): counters, shift register, err_o, resp_valid and resp_data are all cleared; last_grant = DC. After reset: idle_o=1, ready_o=0 unless a request is present.
- Reset mid-operation discards all tracking. Assert memory reset together with this block; stale responses would set err_o.
- Request accepted at edge T → memory samples at T → memory returns at T+10 → resp_valid_o high in cycle T+11. Read latency is 11 cycles.
- Write issued at T → counted in the shift register until T+WR_COMMIT_LAT. idle_o may rise from cycle T+WR_COMMIT_LAT.
- Throughput: 1 request per cycle. Under sustained contention IC and DC alternate.
- drain_i deasserts ready_o in the same cycle. In-flight reads still return.
- Responses are never back-pressured; caches must accept resp_valid unconditionally.

## Test plan
- Reset, then idle: idle_o=1, err_o=0, both ready_o=0, no memory strobes.
- Single IC read of 0x040, memory loaded with line pattern: ic_req_ready_o=1 at T; ic_resp_valid_o at T+11 with the matching 16-byte line; dc_resp_valid_o stays 0.
- Both requesters valid for 6 cycles: grant order IC,DC,IC,DC,IC,DC; responses are routed by tag to the correct cache.
- IC holds valid for 12 cycles with MAX_OUTSTANDING=8: exactly 8 grants, then ready_o=0 until the first response returns (T+10), after which granting resumes.
- DC write of 0xA5 pattern to 0x100 with drain_i asserted the next cycle: no further grants; idle_o=0 until T+5, then 1; a subsequent read returns 0xA5 data.
- Inject mem_data_valid_i with is_instr=1 while ic_cnt=0: err_o=1 and stays set; ic_resp_valid_o=0; ic_cnt remains 0.
